cc_seq_ctrl: RTL and testbench
==============================

Name: cc_seq_ctrl

Overview:
- Sequencer that drives one Candy Crush (CC) game through the CC input protocol: 36-cell board load, then 4 moves, then collection of the score.
- Takes a board/move snapshot from a host through a start handshake and serialises it onto the CC input ports.
- Waits for CC's out_valid, latches out_score, and reports done or timeout.
- Sits between the host/testbench data source and the CC core.

Parameters:
- CELLS, 36, number of board cells (6x6); sets the load length.
- MOVES, 4, number of moves issued per game.
- TIMEOUT, 1000, maximum WAIT cycles for cc_out_valid before aborting.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  host request; accepted only in IDLE.
- board_color  input  108  cell k colour at [3k+2:3k], k=0..35, row-major (row=k/6, col=k%6).
- move_pos  input  24  move m starting position at [6m+5:6m].
- move_action  input  8  move m action at [2m+1:2m].
- move_stripe  input  4  move m stripe flag at bit m.
- busy  output  1  high whenever state is not IDLE.
- cc_in_valid_1  output  1  board-load valid to CC.
- cc_in_color  output  3  cell colour to CC.
- cc_in_valid_2  output  1  move valid to CC.
- cc_in_starting_pos  output  6  move position to CC.
- cc_in_action  output  2  move action to CC.
- cc_in_stripe  output  1  move stripe flag to CC.
- cc_out_valid  input  1  CC result valid.
- cc_out_score  input  7  CC result score.
- done  output  1  one-cycle pulse: score captured.
- timeout  output  1  one-cycle pulse: TIMEOUT expired.
- score  output  7  last captured score; holds until the next done or timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-game aborts immediately: no done/timeout pulse, snapshot discarded.
- All outputs are registered. When its valid is low, each CC data bus is driven 0.
- States: IDLE -> LOAD -> GAP -> MOVE -> WAIT -> IDLE.
- IDLE: start=1 at edge T snapshots board_color, move_pos, move_action, move_stripe, and enters LOAD. Inputs are not sampled again until the next IDLE.
- LOAD: cycles T+1..T+36. cc_in_valid_1=1 and cc_in_color = cell k, with k=0 at T+1, incrementing by 1 per cycle.
- GAP: cycle T+37, all CC valids low.
- MOVE: cycles T+38..T+41. cc_in_valid_2=1 and move m (m=0..3) drives pos, action and stripe together.
- WAIT: entered at T+42; wait counter cleared on entry, +1 per cycle.
  - On the first cycle with cc_out_valid=1: score <= cc_out_score, done=1 for that one next cycle, go to IDLE.
  - If the counter reaches TIMEOUT with no cc_out_valid: score <= 0, timeout=1 for one cycle, go to IDLE.
  - cc_out_valid and a counter terminal in the same cycle: done wins.
- cc_out_valid outside WAIT is ignored.
- start while busy is ignored and not queued. A start in the same cycle as the done/timeout pulse is also ignored; the state is still transitioning to IDLE.
- Earliest restart: start in the first IDLE cycle after the pulse.
- The cell counter is 6 bits and the move counter 2 bits. No wrap escapes: LOAD exits at count 35, MOVE at count 3.
- The wait counter is wide enough for TIMEOUT and saturates; it never wraps.

Test Plan:
- Basic load: board_color with cell k = k%8, start at T -> cc_in_valid_1 high exactly T+1..T+36, cc_in_color sequence 0,1,..,7,0,.., cell 35 = 3; GAP low at T+37.
- Moves: move_pos={6'd35,6'd14,6'd7,6'd0}, move_action=8'b11_10_01_00, move_stripe=4'b1010 -> at T+38..T+41: pos 0,7,14,35; action 0,1,2,3; stripe 0,1,0,1.
- Score capture: cc_out_valid=1 with cc_out_score=7'd93, five cycles into WAIT -> score=93, done pulses exactly one cycle, busy falls in the same cycle, cc_in_valid_1 and cc_in_valid_2 stay 0.
- Timeout: TIMEOUT=20, no cc_out_valid -> timeout pulses one cycle after the 20th WAIT cycle, score=0, done never asserts; then start works again.
- Busy rejection and spurious valid: start re-pulsed during LOAD and cc_out_valid pulsed during MOVE -> sequence unchanged, no early done; second game runs only after a later IDLE start.
- Async reset mid-MOVE: rst asserted between clock edges -> all outputs 0 immediately, no pulse. After release, a new start replays the full 36+1+4 sequence from cell 0.

Source files
------------

// File: rtl/cc_seq_ctrl.sv
// Game sequencer for the Candy Crush core: snapshots a board and four moves from the host,
// streams them onto the CC input ports, then waits for the score or gives up after TIMEOUT cycles.
module cc_seq_ctrl #(
  parameter int CELLS   = 36,
  parameter int MOVES   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3*CELLS-1:0]   board_color,
  input  logic [6*MOVES-1:0]   move_pos,
  input  logic [2*MOVES-1:0]   move_action,
  input  logic [MOVES-1:0]     move_stripe,
  output logic                 busy,
  output logic                 cc_in_valid_1,
  output logic [2:0]           cc_in_color,
  output logic                 cc_in_valid_2,
  output logic [5:0]           cc_in_starting_pos,
  output logic [1:0]           cc_in_action,
  output logic                 cc_in_stripe,
  input  logic                 cc_out_valid,
  input  logic [6:0]           cc_out_score,
  output logic                 done,
  output logic                 timeout,
  output logic [6:0]           score
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    CELL_LAST = 6'(CELLS - 1);
  localparam logic [1:0]    MOVE_LAST = 2'(MOVES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_MAX  = {WW{1'b1}};
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_GAP  = 3'd2,
    S_MOVE = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t          r_state;
  logic [5:0]      r_cell;
  logic [1:0]      r_mv;
  logic [WW-1:0]   r_wait;
  logic [2:0]      r_board  [CELLS];
  logic [5:0]      r_pos    [MOVES];
  logic [1:0]      r_act    [MOVES];
  logic            r_stripe [MOVES];

  logic            r_busy;
  logic            r_valid_1;
  logic [2:0]      r_color;
  logic            r_valid_2;
  logic [5:0]      r_start_pos;
  logic [1:0]      r_action;
  logic            r_stripe_o;
  logic            r_done;
  logic            r_timeout;
  logic [6:0]      r_score;

  // Sequencer FSM; every output is registered and reflects the cell/move counters' current slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cell      <= 6'd0;
      r_mv        <= 2'd0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_valid_1   <= 1'b0;
      r_color     <= 3'd0;
      r_valid_2   <= 1'b0;
      r_start_pos <= 6'd0;
      r_action    <= 2'd0;
      r_stripe_o  <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_score     <= 7'd0;
      for (int k = 0; k < CELLS; k++) r_board[k] <= 3'd0;
      for (int m = 0; m < MOVES; m++) begin
        r_pos[m]    <= 6'd0;
        r_act[m]    <= 2'd0;
        r_stripe[m] <= 1'b0;
      end
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done/timeout pulse belongs to the game just ending.
          if (start && !r_done && !r_timeout) begin
            for (int k = 0; k < CELLS; k++) r_board[k] <= board_color[3*k +: 3];
            for (int m = 0; m < MOVES; m++) begin
              r_pos[m]    <= move_pos[6*m +: 6];
              r_act[m]    <= move_action[2*m +: 2];
              r_stripe[m] <= move_stripe[m];
            end
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_cell    <= 6'd0;
            r_valid_1 <= 1'b1;
            r_color   <= board_color[2:0];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (r_cell == CELL_LAST) begin
            r_state   <= S_GAP;
            r_valid_1 <= 1'b0;
            r_color   <= 3'd0;
          end else begin
            r_cell  <= r_cell + 6'd1;
            r_color <= r_board[r_cell + 6'd1];
          end
        end
        S_GAP: begin
          r_state     <= S_MOVE;
          r_mv        <= 2'd0;
          r_valid_2   <= 1'b1;
          r_start_pos <= r_pos[0];
          r_action    <= r_act[0];
          r_stripe_o  <= r_stripe[0];
        end
        S_MOVE: begin
          if (r_mv == MOVE_LAST) begin
            r_state     <= S_WAIT;
            r_wait      <= '0;
            r_valid_2   <= 1'b0;
            r_start_pos <= 6'd0;
            r_action    <= 2'd0;
            r_stripe_o  <= 1'b0;
          end else begin
            r_mv        <= r_mv + 2'd1;
            r_start_pos <= r_pos[r_mv + 2'd1];
            r_action    <= r_act[r_mv + 2'd1];
            r_stripe_o  <= r_stripe[r_mv + 2'd1];
          end
        end
        S_WAIT: begin
          if (cc_out_valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_score <= cc_out_score;
          end else if (r_wait == WAIT_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_score   <= 7'd0;
          end else if (r_wait != WAIT_MAX) begin
            r_wait <= r_wait + WAIT_ONE;
          end else begin
            r_wait <= r_wait;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_valid_1 <= 1'b0;
          r_valid_2 <= 1'b0;
        end
      endcase
    end
  end

  assign busy               = r_busy;
  assign cc_in_valid_1      = r_valid_1;
  assign cc_in_color        = r_color;
  assign cc_in_valid_2      = r_valid_2;
  assign cc_in_starting_pos = r_start_pos;
  assign cc_in_action       = r_action;
  assign cc_in_stripe       = r_stripe_o;
  assign done               = r_done;
  assign timeout            = r_timeout;
  assign score              = r_score;

endmodule

// File: tb/tb_cc_seq_ctrl.sv
// Directed bench for cc_seq_ctrl: a per-cycle vector table for one full game,
// then hand-written timeout, restart and asynchronous-reset sequences.
module tb_cc_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [107:0] board_color;
  logic [23:0]  move_pos;
  logic [7:0]   move_action;
  logic [3:0]   move_stripe;
  logic         busy, cc_in_valid_1, cc_in_valid_2, cc_in_stripe;
  logic [2:0]   cc_in_color;
  logic [5:0]   cc_in_starting_pos;
  logic [1:0]   cc_in_action;
  logic         cc_out_valid;
  logic [6:0]   cc_out_score;
  logic         done, timeout;
  logic [6:0]   score;

  always #5 clk = ~clk;

  cc_seq_ctrl #(.CELLS(36), .MOVES(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .board_color(board_color), .move_pos(move_pos),
    .move_action(move_action), .move_stripe(move_stripe),
    .busy(busy), .cc_in_valid_1(cc_in_valid_1), .cc_in_color(cc_in_color),
    .cc_in_valid_2(cc_in_valid_2), .cc_in_starting_pos(cc_in_starting_pos),
    .cc_in_action(cc_in_action), .cc_in_stripe(cc_in_stripe),
    .cc_out_valid(cc_out_valid), .cc_out_score(cc_out_score),
    .done(done), .timeout(timeout), .score(score)
  );

  typedef struct {
    logic        start;
    logic        ov;
    logic [6:0]  osc;
    logic [23:0] exp;
  } vec_t;

  vec_t vec [50];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done_seen;
  logic [5:0] pos_tab [4];
  logic       st_tab  [4];
  logic [23:0] w_out;

  assign w_out = {busy, cc_in_valid_1, cc_in_color, cc_in_valid_2, cc_in_starting_pos,
                  cc_in_action, cc_in_stripe, done, timeout, score};

  function automatic logic [23:0] pk(input logic b, input logic v1, input logic [2:0] col,
                                     input logic v2, input logic [5:0] pos, input logic [1:0] act,
                                     input logic st, input logic dn, input logic tmo,
                                     input logic [6:0] sc);
    return {b, v1, col, v2, pos, act, st, dn, tmo, sc};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cc_out_valid = 1'b0; cc_out_score = 7'd0;
    for (int k = 0; k < 36; k++) board_color[3*k +: 3] = 3'(k % 8);
    move_pos    = {6'd35, 6'd14, 6'd7, 6'd0};
    move_action = 8'b11_10_01_00;
    move_stripe = 4'b1010;
    pos_tab[0] = 6'd0; pos_tab[1] = 6'd7; pos_tab[2] = 6'd14; pos_tab[3] = 6'd35;
    st_tab[0] = 1'b0; st_tab[1] = 1'b1; st_tab[2] = 1'b0; st_tab[3] = 1'b1;

    // Game 1 table: entry i is cycle T+i, with start sampled at the end of cycle 0.
    for (int i = 0; i < 50; i++) begin
      vec[i].start = 1'b0; vec[i].ov = 1'b0; vec[i].osc = 7'd0;
      vec[i].exp = pk(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      if (i >= 1 && i <= 36)
        vec[i].exp = pk(1'b1, 1'b1, 3'((i - 1) % 8), 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      if (i == 37 || (i >= 42 && i <= 46))
        vec[i].exp = pk(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      if (i >= 38 && i <= 41)
        vec[i].exp = pk(1'b1, 1'b0, 3'd0, 1'b1, pos_tab[i - 38], 2'(i - 38), st_tab[i - 38],
                        1'b0, 1'b0, 7'd0);
      if (i == 47)
        vec[i].exp = pk(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b1, 1'b0, 7'd93);
      if (i >= 48)
        vec[i].exp = pk(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd93);
    end
    vec[0].start  = 1'b1;
    vec[5].start  = 1'b1;
    vec[40].ov    = 1'b1; vec[40].osc = 7'd55;
    vec[46].ov    = 1'b1; vec[46].osc = 7'd93;
    vec[47].start = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", w_out, 24'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 50; i++) begin
      start = vec[i].start; cc_out_valid = vec[i].ov; cc_out_score = vec[i].osc;
      check($sformatf("game1_cycle%0d", i), w_out, vec[i].exp);
      step();
    end
    start = 1'b0; cc_out_valid = 1'b0; cc_out_score = 7'd0;

    // Game 2: no result ever arrives, so the 20-cycle wait expires.
    start = 1'b1;
    step();
    start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c < 62; c++) begin
      if (done) done_seen = 1'b1;
      if (c == 61) check("tmo_last_wait", w_out,
                         pk(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd93));
      step();
    end
    check("tmo_pulse", w_out, pk(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b1, 7'd0));
    check("tmo_no_done", {23'd0, done_seen}, 24'h0);
    start = 1'b1;
    step();
    check("tmo_single", w_out, pk(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0));

    // Game 3: restart after timeout, then async reset in the middle of the moves.
    step();
    start = 1'b0;
    for (int i = 1; i < 40; i++) begin
      if (i == 1 || i == 36 || i == 39) check($sformatf("game3_cycle%0d", i), w_out, vec[i].exp);
      if (i < 39) step();
    end
    #2 rst = 1'b1;
    #1 check("async_rst", w_out, 24'h0);
    @(negedge clk);
    check("rst_held", w_out, 24'h0);
    rst = 1'b0;
    step();
    check("post_rst_idle", w_out, 24'h0);

    // Game 4: full load and move replay from cell 0 after the reset.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 42; i++) begin
      check($sformatf("game4_cycle%0d", i), w_out, vec[i].exp);
      step();
    end
    check("game4_wait", w_out, pk(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
